// File: rtl/decode_stage.sv
// decode_stage: RV32I/M instruction decode into the ID/EX register.
// Valid/ready on both sides, load-use bubble, illegal flag, stall counter.
module decode_stage #(
  parameter int USE_M         = 0,
  parameter int USE_INTERLOCK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ir,
  input  logic [31:0] pc_in,
  input  logic [31:0] notbranch_in,
  output logic [4:0]  srcreg1_num,
  output logic [4:0]  srcreg2_num,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  dstreg_num,
  output logic [4:0]  ereg1_addr,
  output logic [4:0]  ereg2_addr,
  output logic [31:0] imm,
  output logic [4:0]  alucode,
  output logic        using_r2,
  output logic        using_pc,
  output logic        write_reg,
  output logic [2:0]  info_load,
  output logic [1:0]  info_store,
  output logic [3:0]  info_branch,
  output logic [31:0] pc_out,
  output logic [31:0] notbranch_out,
  output logic        illegal,
  output logic [31:0] bubble_count
);

  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_SLL    = 5'h02;
  localparam logic [4:0] ALU_SLT    = 5'h03;
  localparam logic [4:0] ALU_SLTU   = 5'h04;
  localparam logic [4:0] ALU_XOR    = 5'h05;
  localparam logic [4:0] ALU_SRL    = 5'h06;
  localparam logic [4:0] ALU_SRA    = 5'h07;
  localparam logic [4:0] ALU_OR     = 5'h08;
  localparam logic [4:0] ALU_AND    = 5'h09;
  localparam logic [4:0] ALU_LUI    = 5'h0A;
  localparam logic [4:0] ALU_UNUSED = 5'h0F;
  localparam logic [2:0] NOTLOAD    = 3'b111;
  localparam logic [1:0] NOTSTORE   = 2'b11;
  localparam logic [3:0] NOTBRANCH  = 4'hF;
  localparam logic [3:0] BJAL       = 4'h8;
  localparam logic [3:0] BJALR      = 4'h9;

  typedef struct packed {
    logic [4:0]  dst;
    logic [4:0]  e1;
    logic [4:0]  e2;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        r2;
    logic        upc;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [3:0]  br;
    logic        ill;
  } dec_t;

  localparam dec_t CLR = '{5'd0, 5'd0, 5'd0, 32'd0, ALU_UNUSED,
                           1'b0, 1'b0, 1'b0, NOTLOAD, NOTSTORE,
                           NOTBRANCH, 1'b0};

  function automatic logic [4:0] alu_f3(input logic [2:0] f,
                                        input logic alt);
    logic [4:0] a;
    case (f)
      3'b000:  a = alt ? ALU_SUB : ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = alt ? ALU_SRA : ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  dec_t        dec, dec_q, dec_d;
  logic        r1u, r2u, ill;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d, nb_q, nb_d, cnt_q, cnt_d;
  logic        hazard, fire_in, fire_out;

  assign op    = ir[6:0];
  assign f3    = ir[14:12];
  assign f7    = ir[31:25];
  assign rd    = ir[11:7];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};

  always_comb begin
    dec = CLR;
    r1u = 1'b0;
    r2u = 1'b0;
    ill = 1'b0;
    case (op)
      7'b0110111: begin
        dec.dst = rd; dec.wr = 1'b1; dec.alu = ALU_LUI;
        dec.imm = {ir[31:12], 12'b0};
      end
      7'b0010111: begin
        dec.dst = rd; dec.wr = 1'b1; dec.alu = ALU_ADD;
        dec.upc = 1'b1; dec.imm = {ir[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.dst = rd; dec.wr = 1'b1; dec.alu = ALU_ADD;
        dec.upc = 1'b1; dec.br = BJAL;
        dec.imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      7'b1100111: begin
        r1u = 1'b1;
        dec.dst = rd; dec.wr = 1'b1; dec.alu = ALU_ADD;
        dec.br = BJALR; dec.imm = imm_i;
        ill = (f3 != 3'b000);
      end
      7'b1100011: begin
        r1u = 1'b1; r2u = 1'b1;
        dec.alu = ALU_ADD; dec.upc = 1'b1; dec.br = {1'b0, f3};
        dec.imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
        ill = (f3[2:1] == 2'b01);
      end
      7'b0000011: begin
        r1u = 1'b1;
        dec.dst = rd; dec.wr = 1'b1; dec.alu = ALU_ADD;
        dec.ld = f3; dec.imm = imm_i;
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      7'b0100011: begin
        r1u = 1'b1; r2u = 1'b1;
        dec.alu = ALU_ADD; dec.st = f3[1:0];
        dec.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        ill = (f3 > 3'b010);
      end
      7'b0010011: begin
        r1u = 1'b1;
        dec.dst = rd; dec.wr = 1'b1; dec.imm = imm_i;
        dec.alu = alu_f3(f3, 1'b0);
        // shift-immediates reuse funct7 as an opcode extension
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm = {27'b0, ir[24:20]};
          if (f3 == 3'b101 && f7 == 7'b0100000) dec.alu = ALU_SRA;
          else if (f7 != 7'b0) ill = 1'b1;
        end
      end
      7'b0110011: begin
        r1u = 1'b1; r2u = 1'b1;
        dec.dst = rd; dec.wr = 1'b1; dec.r2 = 1'b1;
        if (f7 == 7'b0)
          dec.alu = alu_f3(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          dec.alu = alu_f3(f3, 1'b1);
        else if (f7 == 7'b0000001 && USE_M != 0)
          dec.alu = 5'h10 + {2'b0, f3};
        else
          ill = 1'b1;
      end
      7'b0001111: ;
      default: ill = 1'b1;
    endcase
    // illegal words travel on as harmless NOPs carrying the flag
    if (ill) begin
      dec     = CLR;
      dec.ill = 1'b1;
    end
    dec.e1 = r1u ? ir[19:15] : 5'd0;
    dec.e2 = r2u ? ir[24:20] : 5'd0;
  end

  assign hazard = (USE_INTERLOCK != 0) && valid_q && in_valid &&
                  dec_q.ld != NOTLOAD && dec_q.dst != 5'd0 &&
                  ((r1u && ir[19:15] == dec_q.dst) ||
                   (r2u && ir[24:20] == dec_q.dst));

  assign in_ready = !flush && !hazard && (!valid_q || out_ready);
  assign fire_in  = in_valid && in_ready;
  assign fire_out = valid_q && out_ready;

  always_comb begin
    dec_d   = dec_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    nb_d    = nb_q;
    cnt_d   = cnt_q;
    if (flush) begin
      dec_d   = CLR;
      valid_d = 1'b0;
    end else if (fire_in) begin
      dec_d   = dec;
      valid_d = 1'b1;
      pc_d    = pc_in;
      nb_d    = notbranch_in;
    end else if (fire_out) begin
      valid_d   = 1'b0;
      dec_d.wr  = 1'b0;
      dec_d.ld  = NOTLOAD;
      dec_d.st  = NOTSTORE;
      dec_d.br  = NOTBRANCH;
      dec_d.alu = ALU_UNUSED;
      dec_d.ill = 1'b0;
    end
    if (!flush && hazard && cnt_q != 32'hFFFF_FFFF)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= CLR;
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      nb_q    <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      dec_q   <= dec_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign srcreg1_num   = ir[19:15];
  assign srcreg2_num   = ir[24:20];
  assign out_valid     = valid_q;
  assign dstreg_num    = dec_q.dst;
  assign ereg1_addr    = dec_q.e1;
  assign ereg2_addr    = dec_q.e2;
  assign imm           = dec_q.imm;
  assign alucode       = dec_q.alu;
  assign using_r2      = dec_q.r2;
  assign using_pc      = dec_q.upc;
  assign write_reg     = dec_q.wr;
  assign info_load     = dec_q.ld;
  assign info_store    = dec_q.st;
  assign info_branch   = dec_q.br;
  assign illegal       = dec_q.ill;
  assign pc_out        = pc_q;
  assign notbranch_out = nb_q;
  assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage.
// dut a: USE_M=1, interlock on; dut b: USE_M=0, interlock off.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  dst;
    logic [4:0]  e1;
    logic [4:0]  e2;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        r2;
    logic        upc;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [3:0]  br;
    logic        ill;
    logic [31:0] pc;
    logic [31:0] nb;
  } obs_t;

  logic clk = 1'b0;
  logic rst, flush, iv_a, iv_b, out_ready;
  logic [31:0] ir, pc_in, nb_in;

  logic a_rdy, a_ov, a_r2, a_upc, a_wr, a_ill;
  logic [4:0] a_s1, a_s2, a_dst, a_e1, a_e2, a_alu;
  logic [31:0] a_imm, a_pc, a_nb, a_cnt;
  logic [2:0] a_ld;
  logic [1:0] a_st;
  logic [3:0] a_br;
  logic b_rdy, b_ov, b_r2, b_upc, b_wr, b_ill;
  logic [4:0] b_s1, b_s2, b_dst, b_e1, b_e2, b_alu;
  logic [31:0] b_imm, b_pc, b_nb, b_cnt;
  logic [2:0] b_ld;
  logic [1:0] b_st;
  logic [3:0] b_br;

  obs_t oa, ob, nexp, lx;
  obs_t qa[$];
  obs_t qb[$];
  logic acc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.USE_M(1), .USE_INTERLOCK(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv_a), .in_ready(a_rdy),
    .ir(ir), .pc_in(pc_in), .notbranch_in(nb_in),
    .srcreg1_num(a_s1), .srcreg2_num(a_s2),
    .out_valid(a_ov), .out_ready(out_ready),
    .dstreg_num(a_dst), .ereg1_addr(a_e1), .ereg2_addr(a_e2),
    .imm(a_imm), .alucode(a_alu),
    .using_r2(a_r2), .using_pc(a_upc), .write_reg(a_wr),
    .info_load(a_ld), .info_store(a_st), .info_branch(a_br),
    .pc_out(a_pc), .notbranch_out(a_nb),
    .illegal(a_ill), .bubble_count(a_cnt)
  );

  decode_stage #(.USE_M(0), .USE_INTERLOCK(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv_b), .in_ready(b_rdy),
    .ir(ir), .pc_in(pc_in), .notbranch_in(nb_in),
    .srcreg1_num(b_s1), .srcreg2_num(b_s2),
    .out_valid(b_ov), .out_ready(out_ready),
    .dstreg_num(b_dst), .ereg1_addr(b_e1), .ereg2_addr(b_e2),
    .imm(b_imm), .alucode(b_alu),
    .using_r2(b_r2), .using_pc(b_upc), .write_reg(b_wr),
    .info_load(b_ld), .info_store(b_st), .info_branch(b_br),
    .pc_out(b_pc), .notbranch_out(b_nb),
    .illegal(b_ill), .bubble_count(b_cnt)
  );

  assign oa = {a_dst, a_e1, a_e2, a_imm, a_alu, a_r2, a_upc, a_wr,
               a_ld, a_st, a_br, a_ill, a_pc, a_nb};
  assign ob = {b_dst, b_e1, b_e2, b_imm, b_alu, b_r2, b_upc, b_wr,
               b_ld, b_st, b_br, b_ill, b_pc, b_nb};

  function automatic obs_t mk(
    input logic [4:0] dst, e1, e2, input logic [31:0] im,
    input logic [4:0] alu, input logic r2, upc, wr,
    input logic [2:0] ld, input logic [1:0] st,
    input logic [3:0] br, input logic ill);
    obs_t e;
    e = {dst, e1, e2, im, alu, r2, upc, wr, ld, st, br, ill,
         32'd0, 32'd0};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chko(input string tag, input obs_t got,
                      input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    obs_t e;
    #1;
    if (iv_a && a_rdy) begin qa.push_back(nexp); acc = 1'b1; end
    if (iv_b && b_rdy) begin qb.push_back(nexp); acc = 1'b1; end
    if (a_ov && out_ready) begin
      if (qa.size() == 0) chk("sb_a_empty", qa.size(), 32'd1);
      else begin e = qa.pop_front(); chko("sb_a", oa, e); end
    end else if (a_ov && flush && qa.size() != 0)
      e = qa.pop_front();
    if (b_ov && out_ready) begin
      if (qb.size() == 0) chk("sb_b_empty", qb.size(), 32'd1);
      else begin e = qb.pop_front(); chko("sb_b", ob, e); end
    end else if (b_ov && flush && qb.size() != 0)
      e = qb.pop_front();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit to_b, input logic [31:0] w,
                       input logic [31:0] pc, input obs_t e);
    ir = w; pc_in = pc; nb_in = pc + 32'd4;
    nexp = e; nexp.pc = pc; nexp.nb = pc + 32'd4;
    acc = 1'b0;
    if (to_b) iv_b = 1'b1;
    else iv_a = 1'b1;
  endtask

  task automatic issue(input bit to_b, input logic [31:0] w,
                       input logic [31:0] pc, input obs_t e);
    drive(to_b, w, pc, e);
    for (int i = 0; i < 8 && !acc; i++) cyc();
    iv_a = 1'b0; iv_b = 1'b0;
    chk("accept", 32'(acc), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; iv_a = 1'b0; iv_b = 1'b0;
    out_ready = 1'b0; ir = 32'h13; pc_in = 0; nb_in = 0;
    acc = 1'b0; nexp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(a_ov), 32'd0);
    chk("rst_ld", 32'(a_ld), 32'd7);
    chk("rst_alu", 32'(a_alu), 32'h0F);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_pc", a_pc, 32'd0);
    chk("rst_ov_b", 32'(b_ov), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_rdy_a", 32'(a_rdy), 32'd1);
    chk("rel_rdy_b", 32'(b_rdy), 32'd1);

    out_ready = 1'b1;
    // addi x5,x1,-3
    issue(0, 32'hFFD08293, 32'h100,
      mk(5, 1, 0, 32'hFFFFFFFD, 5'h00, 0, 0, 1, 3'd7, 2'd3, 4'hF, 0));
    cyc();
    chk("idle_ov", 32'(a_ov), 32'd0);

    // lw x6,0(x2) then dependent add x7,x6,x6
    issue(0, 32'h00012303, 32'h104,
      mk(6, 2, 0, 32'd0, 5'h00, 0, 0, 1, 3'd2, 2'd3, 4'hF, 0));
    drive(0, 32'h006303B3, 32'h108,
      mk(7, 6, 6, 32'd0, 5'h00, 1, 0, 1, 3'd7, 2'd3, 4'hF, 0));
    #1;
    chk("haz_rdy", 32'(a_rdy), 32'd0);
    chk("src1", 32'(a_s1), 32'd6);
    chk("src2", 32'(a_s2), 32'd6);
    cyc();
    chk("bubble_ov", 32'(a_ov), 32'd0);
    cyc();
    chk("bubble_acc", 32'(acc), 32'd1);
    iv_a = 1'b0;
    cyc();
    chk("bubble_cnt", a_cnt, 32'd1);

    // backpressure: lui held 3 cycles while sw waits
    out_ready = 1'b0;
    lx = mk(10, 0, 0, 32'h12345000, 5'h0A, 0, 0, 1, 3'd7, 2'd3,
            4'hF, 0);
    issue(0, 32'h12345537, 32'h10C, lx);
    lx.pc = 32'h10C; lx.nb = 32'h110;
    drive(0, 32'h00512423, 32'h110,
      mk(0, 2, 5, 32'd8, 5'h00, 0, 0, 0, 3'd7, 2'd2, 4'hF, 0));
    repeat (3) begin
      #1;
      chk("bp_rdy", 32'(a_rdy), 32'd0);
      chko("bp_hold", oa, lx);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_acc", 32'(acc), 32'd1);
    iv_a = 1'b0;
    cyc();

    // flush kills a held beq and drops the incoming word
    out_ready = 1'b0;
    issue(0, 32'h00208863, 32'h114,
      mk(0, 1, 2, 32'd16, 5'h00, 0, 1, 0, 3'd7, 2'd3, 4'h0, 0));
    drive(0, 32'hFFD08293, 32'h200,
      mk(5, 1, 0, 32'hFFFFFFFD, 5'h00, 0, 0, 1, 3'd7, 2'd3, 4'hF, 0));
    flush = 1'b1;
    cyc();
    flush = 1'b0; iv_a = 1'b0;
    chk("fl_acc", 32'(acc), 32'd0);
    chk("fl_ov", 32'(a_ov), 32'd0);
    chk("fl_pc", a_pc, 32'h114);
    chk("fl_br", 32'(a_br), 32'hF);
    chk("fl_q", qa.size(), 32'd0);
    out_ready = 1'b1;

    // flush coinciding with a load-use hazard: no bubble counted
    issue(0, 32'h00012303, 32'h118,
      mk(6, 2, 0, 32'd0, 5'h00, 0, 0, 1, 3'd2, 2'd3, 4'hF, 0));
    drive(0, 32'h006303B3, 32'h11C,
      mk(7, 6, 6, 32'd0, 5'h00, 1, 0, 1, 3'd7, 2'd3, 4'hF, 0));
    flush = 1'b1;
    cyc();
    flush = 1'b0; iv_a = 1'b0;
    chk("flhz_ov", 32'(a_ov), 32'd0);
    chk("flhz_cnt", a_cnt, 32'd1);

    // back-to-back: mul, jal, srai, ecall, illegal lw funct3
    issue(0, 32'h022081B3, 32'h120,
      mk(3, 1, 2, 32'd0, 5'h10, 1, 0, 1, 3'd7, 2'd3, 4'hF, 0));
    issue(0, 32'h008000EF, 32'h124,
      mk(1, 0, 0, 32'd8, 5'h00, 0, 1, 1, 3'd7, 2'd3, 4'h8, 0));
    issue(0, 32'h40325213, 32'h128,
      mk(4, 4, 0, 32'd3, 5'h07, 0, 0, 1, 3'd7, 2'd3, 4'hF, 0));
    issue(0, 32'h00000073, 32'h12C,
      mk(0, 0, 0, 32'd0, 5'h0F, 0, 0, 0, 3'd7, 2'd3, 4'hF, 1));
    issue(0, 32'h00013303, 32'h130,
      mk(0, 2, 0, 32'd0, 5'h0F, 0, 0, 0, 3'd7, 2'd3, 4'hF, 1));
    cyc();
    cyc();

    // dut b: no interlock, RV32M illegal
    issue(1, 32'h00012303, 32'h300,
      mk(6, 2, 0, 32'd0, 5'h00, 0, 0, 1, 3'd2, 2'd3, 4'hF, 0));
    drive(1, 32'h006303B3, 32'h304,
      mk(7, 6, 6, 32'd0, 5'h00, 1, 0, 1, 3'd7, 2'd3, 4'hF, 0));
    #1;
    chk("noil_rdy", 32'(b_rdy), 32'd1);
    cyc();
    iv_b = 1'b0;
    chk("noil_acc", 32'(acc), 32'd1);
    issue(1, 32'h022081B3, 32'h308,
      mk(0, 1, 2, 32'd0, 5'h0F, 0, 0, 0, 3'd7, 2'd3, 4'hF, 1));
    chk("mul_b_ov", 32'(b_ov), 32'd1);
    cyc();
    cyc();
    chk("noil_cnt", b_cnt, 32'd0);
    chk("drain_a", qa.size(), 32'd0);
    chk("drain_b", qb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
